// File: rtl/ro_puf_pkg.sv
// ----------------------------------------------------------------------------
// ro_puf_pkg
// Shared definitions for the RO-PUF comparator slice: the measurement FSM
// state encoding and the default mux-select / edge-counter widths.
// No ports (package).
// ----------------------------------------------------------------------------
package ro_puf_pkg;

  localparam int DEF_SEL_W = 3;
  localparam int DEF_CNT_W = 16;

  // ST_ prefix keeps the SETTLE state name clear of the SETTLE parameter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_COUNT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_puf_compare_if.sv
// ----------------------------------------------------------------------------
// ro_puf_compare_if
// Bundles the challenge request handshake, the oscillator mux/control lines
// and the response handshake of ro_puf_compare.
//   slave  : the comparator (drives ready, selects, osc controls, response)
//   master : the environment (drives start/challenge, osc outputs, resp_ready)
// ----------------------------------------------------------------------------
interface ro_puf_compare_if #(
  parameter int SEL_W = ro_puf_pkg::DEF_SEL_W,
  parameter int CNT_W = ro_puf_pkg::DEF_CNT_W
);

  logic               start;
  logic [2*SEL_W-1:0] challenge;
  logic               ready;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic               ro_rst;
  logic               ro_enable;
  logic               ro_a;
  logic               ro_b;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp;
  logic               tie;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;

  modport slave (
    input  start, challenge, ro_a, ro_b, resp_ready,
    output ready, sel_a, sel_b, ro_rst, ro_enable,
           resp_valid, resp, tie, cnt_a, cnt_b
  );

  modport master (
    output start, challenge, ro_a, ro_b, resp_ready,
    input  ready, sel_a, sel_b, ro_rst, ro_enable,
           resp_valid, resp, tie, cnt_a, cnt_b
  );

endinterface

// File: rtl/ro_edge_counter.sv
// ----------------------------------------------------------------------------
// ro_edge_counter
// Brings one asynchronous oscillator output into the clk domain through a
// 2-flop synchronizer, detects its rising edges and counts them into a
// saturating counter.
//   clk, rst   : clock, asynchronous active-low reset
//   ro_in      : oscillator output, asynchronous to clk
//   clr        : synchronous clear of the count (wins over en)
//   en         : count detected edges while high
//   count      : registered count
//   count_nxt  : value count takes at the next edge
// ----------------------------------------------------------------------------
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic sync_q1;
  logic sync_q2;
  logic rise;

  assign rise = sync_q1 && !sync_q2;

  // Stops at all-ones instead of wrapping so a fast oscillator never
  // appears slower than a slow one.
  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (en && rise && (count != '1))
      count_nxt = count + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      count   <= '0;
    end else begin
      sync_q1 <= ro_in;
      sync_q2 <= sync_q1;
      count   <= count_nxt;
    end
  end

endmodule

// File: rtl/ro_puf_compare.sv
// ----------------------------------------------------------------------------
// ro_puf_compare
// Takes a challenge (two oscillator selects), resets and enables the ring
// oscillators, lets the synchronizers settle, counts rising edges of both
// selected oscillators over a WINDOW-cycle gate and returns one response
// bit (cnt_a > cnt_b), a tie flag and both raw counts via valid/ready.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ro_puf_compare_if slave (request, oscillator, response)
// ----------------------------------------------------------------------------
module ro_puf_compare
  import ro_puf_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WINDOW  = 1024,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 3
) (
  input logic              clk,
  input logic              rst,
  ro_puf_compare_if.slave  bus
);

  localparam int PH_MAX = (RST_CYC > SETTLE)
                          ? ((RST_CYC > WINDOW) ? RST_CYC : WINDOW)
                          : ((SETTLE  > WINDOW) ? SETTLE  : WINDOW);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  // Each phase lasts load+1 cycles, counting down to zero
  localparam logic [PH_W-1:0] RST_LOAD = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] SET_LOAD = PH_W'(SETTLE - 1);
  localparam logic [PH_W-1:0] WIN_LOAD = PH_W'(WINDOW - 1);
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic             accept;
  logic             counting;
  logic [CNT_W-1:0] a_cnt, a_nxt;
  logic [CNT_W-1:0] b_cnt, b_nxt;

  assign accept   = (state == ST_IDLE) && bus.start;
  assign counting = (state == ST_COUNT);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (clk),
    .rst      (rst),
    .ro_in    (bus.ro_a),
    .clr      (accept),
    .en       (counting),
    .count    (a_cnt),
    .count_nxt(a_nxt)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (clk),
    .rst      (rst),
    .ro_in    (bus.ro_b),
    .clr      (accept),
    .en       (counting),
    .count    (b_cnt),
    .count_nxt(b_nxt)
  );

  assign bus.cnt_a = a_cnt;
  assign bus.cnt_b = b_cnt;

  // resp/tie are taken from the counters' next values on the last COUNT
  // cycle so they already include an edge landing on that final cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      phase          <= '0;
      bus.ready      <= 1'b1;
      bus.sel_a      <= '0;
      bus.sel_b      <= '0;
      bus.ro_rst     <= 1'b0;
      bus.ro_enable  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp       <= 1'b0;
      bus.tie        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            bus.sel_a     <= bus.challenge[SEL_W-1:0];
            bus.sel_b     <= bus.challenge[2*SEL_W-1:SEL_W];
            bus.ready     <= 1'b0;
            bus.ro_rst    <= 1'b1;
            bus.ro_enable <= 1'b1;
            phase         <= RST_LOAD;
            state         <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (phase == '0) begin
            bus.ro_rst <= 1'b0;
            phase      <= SET_LOAD;
            state      <= ST_SETTLE;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
        ST_SETTLE: begin
          if (phase == '0) begin
            phase <= WIN_LOAD;
            state <= ST_COUNT;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
        ST_COUNT: begin
          if (phase == '0) begin
            bus.ro_enable  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp       <= (a_nxt > b_nxt);
            bus.tie        <= (a_nxt == b_nxt);
            phase          <= '0;
            state          <= ST_DONE;
          end else begin
            phase <= phase - PH_ONE;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.ready      <= 1'b1;
            phase          <= '0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_compare.sv
// ----------------------------------------------------------------------------
// tb_ro_puf_compare
// Directed bench for ro_puf_compare. A main instance (CNT_W=16, WINDOW=24)
// sees square waves of period 4 and 6 clk; a second instance with CNT_W=3
// sees periods 2 and 8 so its A counter saturates.
// ----------------------------------------------------------------------------
module tb_ro_puf_compare;

  logic       clk;
  logic       rst;
  logic       w2, w4, w6, w8;
  logic [1:0] mode;
  int         n_cmp;
  int         n_err;
  int         seen_valid;

  ro_puf_compare_if #(.SEL_W(3), .CNT_W(16)) bus ();
  ro_puf_compare_if #(.SEL_W(3), .CNT_W(3))  bus_s ();

  ro_puf_compare #(
    .SEL_W(3), .CNT_W(16), .WINDOW(24), .RST_CYC(2), .SETTLE(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ro_puf_compare #(
    .SEL_W(3), .CNT_W(3), .WINDOW(24), .RST_CYC(2), .SETTLE(3)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  // mode 0: A=p4 B=p6, mode 1: swapped, mode 2: both p4
  assign bus.ro_a   = (mode == 2'd1) ? w6 : w4;
  assign bus.ro_b   = (mode == 2'd0) ? w6 : w4;
  assign bus_s.ro_a = w2;
  assign bus_s.ro_b = w8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillator waves toggle 2 ns after a multiple of 10 ns, away from clk edges
  initial begin w2 = 1'b0; #2; forever #10 w2 = ~w2; end
  initial begin w4 = 1'b0; #2; forever #20 w4 = ~w4; end
  initial begin w6 = 1'b0; #2; forever #30 w6 = ~w6; end
  initial begin w8 = 1'b0; #2; forever #40 w8 = ~w8; end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("[TB] check %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a challenge for one cycle; returns just after the accept edge
  task automatic apply_stimulus(input logic [5:0] ch);
    bus.challenge = ch;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, bus.resp_valid, 1);
  endtask

  task automatic check_result(input string tag, input int ea, input int eb, input logic er, input logic et);
    check_output({tag, "_cnt_a"}, bus.cnt_a, ea);
    check_output({tag, "_cnt_b"}, bus.cnt_b, eb);
    check_output({tag, "_resp"},  bus.resp,  er);
    check_output({tag, "_tie"},   bus.tie,   et);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mode  = 2'd0;
    rst   = 1'b0;
    bus.start        = 1'b0;
    bus.challenge    = '0;
    bus.resp_ready   = 1'b0;
    bus_s.start      = 1'b0;
    bus_s.challenge  = '0;
    bus_s.resp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check_output("rst_ready",      bus.ready,      1);
    check_output("rst_sel_a",      bus.sel_a,      0);
    check_output("rst_sel_b",      bus.sel_b,      0);
    check_output("rst_ro_rst",     bus.ro_rst,     0);
    check_output("rst_ro_enable",  bus.ro_enable,  0);
    check_output("rst_resp_valid", bus.resp_valid, 0);
    check_output("rst_resp",       bus.resp,       0);
    check_output("rst_tie",        bus.tie,        0);
    check_output("rst_cnt_a",      bus.cnt_a,      0);
    check_output("rst_cnt_b",      bus.cnt_b,      0);
    rst = 1'b1;
    @(negedge clk);

    // Test 1: A=p4, B=p6, exact latency, held response, ignored start
    $display("[TB] test 1: A period 4, B period 6");
    apply_stimulus(6'b010_001);
    check_output("t1_ready_low", bus.ready,     0);
    check_output("t1_sel_a",     bus.sel_a,     1);
    check_output("t1_sel_b",     bus.sel_b,     2);
    check_output("t1_ro_rst_on", bus.ro_rst,    1);
    check_output("t1_ro_en_on",  bus.ro_enable, 1);
    repeat (2) @(negedge clk);
    check_output("t1_settle_ro_rst", bus.ro_rst,    0);
    check_output("t1_settle_ro_en",  bus.ro_enable, 1);
    repeat (26) @(negedge clk);
    check_output("t1_valid_not_early", bus.resp_valid, 0);
    @(negedge clk);
    check_output("t1_valid_on_time", bus.resp_valid, 1);
    check_output("t1_done_ro_en",    bus.ro_enable,  0);
    for (int i = 0; i < 5; i++) begin
      check_output("t1_hold_valid", bus.resp_valid, 1);
      check_output("t1_hold_ready", bus.ready,      0);
      check_result("t1_hold", 6, 4, 1'b1, 1'b0);
      bus.start = (i == 1);
      if (i == 1) bus.challenge = 6'b111_111;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_output("t1_ignored_sel_a", bus.sel_a, 1);
    check_output("t1_ignored_sel_b", bus.sel_b, 2);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_output("t1_after_hs_valid", bus.resp_valid, 0);
    check_output("t1_after_hs_ready", bus.ready,      1);
    check_result("t1_idle_keep", 6, 4, 1'b1, 1'b0);

    // Test 2: sources swapped, resp_ready already high before valid
    $display("[TB] test 2: sources swapped");
    mode = 2'd1;
    bus.resp_ready = 1'b1;
    apply_stimulus(6'b010_001);
    wait_valid("t2_valid", 60);
    check_result("t2", 4, 6, 1'b0, 1'b0);
    @(negedge clk);
    check_output("t2_valid_drop", bus.resp_valid, 0);
    check_output("t2_ready_back", bus.ready,      1);

    // Test 3: identical periods give a tie
    $display("[TB] test 3: both period 4");
    mode = 2'd2;
    apply_stimulus(6'b011_011);
    wait_valid("t3_valid", 60);
    check_result("t3", 6, 6, 1'b0, 1'b1);
    @(negedge clk);

    // Test 4: 3-bit counters, A saturates
    $display("[TB] test 4: saturation instance");
    bus_s.challenge = 6'b100_111;
    bus_s.start     = 1'b1;
    @(negedge clk);
    bus_s.start     = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 60 && seen_valid == 0; i++) begin
      if (bus_s.resp_valid === 1'b1) seen_valid = 1;
      else @(negedge clk);
    end
    check_output("t4_valid",  bus_s.resp_valid, 1);
    check_output("t4_sel_a",  bus_s.sel_a,      7);
    check_output("t4_sel_b",  bus_s.sel_b,      4);
    check_output("t4_cnt_a",  bus_s.cnt_a,      7);
    check_output("t4_cnt_b",  bus_s.cnt_b,      3);
    check_output("t4_resp",   bus_s.resp,       1);
    check_output("t4_tie",    bus_s.tie,        0);
    @(negedge clk);

    // Test 5: reset in the middle of COUNT
    $display("[TB] test 5: reset during count");
    mode = 2'd0;
    apply_stimulus(6'b011_101);
    check_output("t5_sel_a", bus.sel_a, 5);
    check_output("t5_sel_b", bus.sel_b, 3);
    repeat (10) @(negedge clk);
    check_output("t5_counting_en", bus.ro_enable, 1);
    rst = 1'b0;
    #1;
    check_output("t5_ready",      bus.ready,      1);
    check_output("t5_sel_a_rst",  bus.sel_a,      0);
    check_output("t5_sel_b_rst",  bus.sel_b,      0);
    check_output("t5_ro_rst",     bus.ro_rst,     0);
    check_output("t5_ro_enable",  bus.ro_enable,  0);
    check_output("t5_resp_valid", bus.resp_valid, 0);
    check_result("t5_rst", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) seen_valid = 1;
    end
    check_output("t5_no_valid", seen_valid, 0);
    apply_stimulus(6'b010_001);
    wait_valid("t5_rerun_valid", 60);
    check_result("t5_rerun", 6, 4, 1'b1, 1'b0);
    @(negedge clk);
    check_output("t5_rerun_ready", bus.ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
